buzzer_driver: RTL and testbench

- Downstream consumer of the alarm/chime control stage.
- Turns the one-second `alarm_ring` / `time_ring` level pulses into a timed, audible buzzer square wave.
- Alarm gets a long, beeping (gated) tone that the user can stop. The hourly chime gets a short, continuous lower tone.
- Output drives the board buzzer pin directly; status flags drive LEDs.

---
 rtl/buzzer_pkg.sv | 23 ++
 rtl/buzzer_if.sv | 32 +++
 rtl/tone_gen.sv | 42 ++++
 rtl/buzzer_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_buzzer_driver.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer driver.
//   state_e     : driver state (IDLE, ALARM, CHIME, SNOOZE)
//   MODE_NORMAL : clock mode value in which the buzzer may sound
//   SEC_W       : width of the per-state seconds counter
package buzzer_pkg;

   localparam int unsigned SEC_W       = 6;
   localparam logic [1:0]  MODE_NORMAL = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALARM  = 2'd1,
      CHIME  = 2'd2,
      SNOOZE = 2'd3
   } state_e;

   // Tone counter half period in system clocks (integer division).
   function automatic int unsigned half_period(input int unsigned clk_hz,
                                               input int unsigned tone_hz);
      return clk_hz / (2 * tone_hz);
   endfunction

endpackage

// File: rtl/buzzer_if.sv
// Control/status bundle between the alarm control stage, the buzzer driver
// and the board pins.
//   clk_1hz      : one-cycle pulse per second
//   mode         : clock mode (2'b00 normal)
//   alarm_ring   : alarm trigger level
//   time_ring    : hourly chime trigger level
//   stop_key     : debounced one-cycle stop pulse
//   buzzer       : square-wave buzzer drive
//   alarm_active : alarm (or snooze) in progress
//   chime_active : chime in progress
interface buzzer_if;

   logic       clk_1hz;
   logic [1:0] mode;
   logic       alarm_ring;
   logic       time_ring;
   logic       stop_key;
   logic       buzzer;
   logic       alarm_active;
   logic       chime_active;

   modport master (
      output clk_1hz, mode, alarm_ring, time_ring, stop_key,
      input  buzzer, alarm_active, chime_active
   );

   modport slave (
      input  clk_1hz, mode, alarm_ring, time_ring, stop_key,
      output buzzer, alarm_active, chime_active
   );

endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles o_wave every HALF enabled clocks.
// Clear or disable forces the counter and the wave to 0, so a new segment
// always starts with a full low half period.
//   clk, rst_n : clock, async active-low reset
//   i_enable   : run the tone
//   i_clear    : restart the tone from its low phase
//   o_wave     : registered square wave
module tone_gen #(
   parameter int unsigned HALF  = 5,
   parameter int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_wave
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_wave;

   // Half-period counter and output toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_wave <= 1'b0;
      end else if (i_clear || !i_enable) begin
         r_cnt  <= '0;
         r_wave <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt  <= '0;
         r_wave <= ~r_wave;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign o_wave = r_wave;

endmodule

// File: rtl/buzzer_driver.sv
// Buzzer driver: turns alarm / hourly-chime trigger levels into a timed
// square-wave buzzer drive. Alarm gives a beeping tone (one second on, one
// second off) that stop_key ends; the chime gives a short continuous tone.
// Optional build macro BUZZER_SNOOZE_EN: stop_key during the alarm snoozes
// it for SNOOZE_SECONDS before ringing again.
//   clk, rst_n          : clock, async active-low reset
//   bus (buzzer_if.slave): clk_1hz, mode, alarm_ring, time_ring, stop_key in;
//                          buzzer, alarm_active, chime_active out
module buzzer_driver
   import buzzer_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned ALARM_TONE_HZ  = 2000,
   parameter int unsigned CHIME_TONE_HZ  = 1000,
   parameter int unsigned ALARM_SECONDS  = 30,
   parameter int unsigned CHIME_SECONDS  = 2
`ifdef BUZZER_SNOOZE_EN
   ,
   parameter int unsigned SNOOZE_SECONDS = 60
`endif
) (
   input  logic     clk,
   input  logic     rst_n,
   buzzer_if.slave  bus
);

   localparam int unsigned ALARM_HALF = half_period(CLK_HZ, ALARM_TONE_HZ);
   localparam int unsigned CHIME_HALF = half_period(CLK_HZ, CHIME_TONE_HZ);
   localparam int unsigned MAX_HALF   = (ALARM_HALF > CHIME_HALF) ? ALARM_HALF : CHIME_HALF;
   localparam int unsigned TONE_W     = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

   localparam logic [SEC_W-1:0] ALARM_LOAD  = SEC_W'(ALARM_SECONDS);
   localparam logic [SEC_W-1:0] CHIME_LOAD  = SEC_W'(CHIME_SECONDS);
`ifdef BUZZER_SNOOZE_EN
   localparam logic [SEC_W-1:0] SNOOZE_LOAD = SEC_W'(SNOOZE_SECONDS);
`endif
   localparam logic [SEC_W-1:0] SEC_ONE     = SEC_W'(1);

   state_e           r_state;
   state_e           w_next_state;
   logic [SEC_W-1:0] r_sec;
   logic [SEC_W-1:0] w_next_sec;
   logic             r_phase;
   logic             w_next_phase;
   logic             w_entry;
   logic             r_alarm_d;
   logic             r_time_d;
   logic             r_alarm_active;
   logic             r_chime_active;
   logic             w_alarm_edge;
   logic             w_time_edge;
   logic             w_alarm_en;
   logic             w_alarm_clr;
   logic             w_chime_en;
   logic             w_chime_clr;
   logic             w_alarm_wave;
   logic             w_chime_wave;

   // Rising-edge detection: a held level never retriggers.
   assign w_alarm_edge = bus.alarm_ring & ~r_alarm_d;
   assign w_time_edge  = bus.time_ring  & ~r_time_d;

   // State, second counter, beep phase, edge history and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_sec          <= '0;
         r_phase        <= 1'b0;
         r_alarm_d      <= 1'b0;
         r_time_d       <= 1'b0;
         r_alarm_active <= 1'b0;
         r_chime_active <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_sec          <= w_next_sec;
         r_phase        <= w_next_phase;
         r_alarm_d      <= bus.alarm_ring;
         r_time_d       <= bus.time_ring;
         r_alarm_active <= (w_next_state == ALARM) || (w_next_state == SNOOZE);
         r_chime_active <= (w_next_state == CHIME);
      end
   end

   // Next state. Entries take priority over stop_key and over a clk_1hz in
   // the same cycle; a non-normal mode overrides everything.
   always_comb begin
      w_next_state = r_state;
      w_next_sec   = r_sec;
      w_next_phase = r_phase;
      w_entry      = 1'b0;
      if (bus.mode != MODE_NORMAL) begin
         w_next_state = IDLE;
         w_next_sec   = '0;
         w_next_phase = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_alarm_edge) begin
                  w_next_state = ALARM;
                  w_next_sec   = ALARM_LOAD;
                  w_next_phase = 1'b1;
                  w_entry      = 1'b1;
               end else if (w_time_edge) begin
                  w_next_state = CHIME;
                  w_next_sec   = CHIME_LOAD;
                  w_next_phase = 1'b0;
                  w_entry      = 1'b1;
               end
            end
            ALARM: begin
               if (bus.stop_key) begin
`ifdef BUZZER_SNOOZE_EN
                  w_next_state = SNOOZE;
                  w_next_sec   = SNOOZE_LOAD;
`else
                  w_next_state = IDLE;
                  w_next_sec   = '0;
`endif
                  w_next_phase = 1'b0;
               end else if (bus.clk_1hz) begin
                  if (r_sec == SEC_ONE) begin
                     w_next_state = IDLE;
                     w_next_sec   = '0;
                     w_next_phase = 1'b0;
                  end else begin
                     w_next_sec   = r_sec - 1'b1;
                     w_next_phase = ~r_phase;
                  end
               end
            end
            CHIME: begin
               if (w_alarm_edge) begin
                  w_next_state = ALARM;
                  w_next_sec   = ALARM_LOAD;
                  w_next_phase = 1'b1;
                  w_entry      = 1'b1;
               end else if (bus.stop_key) begin
                  w_next_state = IDLE;
                  w_next_sec   = '0;
               end else if (bus.clk_1hz) begin
                  if (r_sec == SEC_ONE) begin
                     w_next_state = IDLE;
                     w_next_sec   = '0;
                  end else begin
                     w_next_sec   = r_sec - 1'b1;
                  end
               end
            end
`ifdef BUZZER_SNOOZE_EN
            SNOOZE: begin
               if (w_alarm_edge) begin
                  w_next_state = ALARM;
                  w_next_sec   = ALARM_LOAD;
                  w_next_phase = 1'b1;
                  w_entry      = 1'b1;
               end else if (w_time_edge) begin
                  // The chime wins and the pending snooze is dropped.
                  w_next_state = CHIME;
                  w_next_sec   = CHIME_LOAD;
                  w_next_phase = 1'b0;
                  w_entry      = 1'b1;
               end else if (bus.stop_key) begin
                  w_next_state = IDLE;
                  w_next_sec   = '0;
               end else if (bus.clk_1hz) begin
                  if (r_sec == SEC_ONE) begin
                     w_next_state = ALARM;
                     w_next_sec   = ALARM_LOAD;
                     w_next_phase = 1'b1;
                     w_entry      = 1'b1;
                  end else begin
                     w_next_sec   = r_sec - 1'b1;
                  end
               end
            end
`endif
            default: begin
               w_next_state = IDLE;
               w_next_sec   = '0;
               w_next_phase = 1'b0;
            end
         endcase
      end
   end

   // Enables follow the next state so the buzzer drops on the same edge the
   // state leaves; a beep restarts its tone from zero each time phase rises.
   assign w_alarm_en  = (w_next_state == ALARM) && w_next_phase;
   assign w_alarm_clr = w_entry || (w_next_phase && !r_phase);
   assign w_chime_en  = (w_next_state == CHIME);
   assign w_chime_clr = w_entry;

   tone_gen #(
      .HALF  (ALARM_HALF),
      .CNT_W (TONE_W)
   ) u_alarm_tone (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (w_alarm_en),
      .i_clear  (w_alarm_clr),
      .o_wave   (w_alarm_wave)
   );

   tone_gen #(
      .HALF  (CHIME_HALF),
      .CNT_W (TONE_W)
   ) u_chime_tone (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (w_chime_en),
      .i_clear  (w_chime_clr),
      .o_wave   (w_chime_wave)
   );

   // At most one generator is enabled, so the OR selects between two flops.
   assign bus.buzzer       = w_alarm_wave | w_chime_wave;
   assign bus.alarm_active = r_alarm_active;
   assign bus.chime_active = r_chime_active;

endmodule

// File: tb/tb_buzzer_driver.sv
// Testbench for buzzer_driver with small sim parameters. A behavioural model
// tracks which sound is playing, seconds elapsed and cycles since the audible
// segment began; the expected buzzer level is derived arithmetically.
module tb_buzzer_driver;

   localparam int unsigned AL_HALF = 5;
   localparam int unsigned CH_HALF = 10;
   localparam int unsigned AL_S    = 4;
   localparam int unsigned CH_S    = 2;
   localparam int unsigned SN_S    = 3;

   typedef enum int {M_IDLE, M_ALARM, M_CHIME, M_SNOOZE} mstate_e;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   mstate_e m_st;
   int      m_ticks;
   int      m_seg;
   bit      m_prev_a;
   bit      m_prev_t;

   buzzer_if bus ();

   buzzer_driver #(
      .CLK_HZ        (1000),
      .ALARM_TONE_HZ (100),
      .CHIME_TONE_HZ (50),
      .ALARM_SECONDS (AL_S),
      .CHIME_SECONDS (CH_S)
`ifdef BUZZER_SNOOZE_EN
      ,
      .SNOOZE_SECONDS(SN_S)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_st = M_IDLE; m_ticks = 0; m_seg = 0; m_prev_a = 0; m_prev_t = 0;
   endfunction

   // One clock of the reference behaviour, given the inputs seen at that edge.
   function automatic void model_step(bit a, bit t, bit s, bit k, bit [1:0] md);
      bit ae = a && !m_prev_a;
      bit te = t && !m_prev_t;
      bit restart = 0;
      m_prev_a = a;
      m_prev_t = t;
      if (md != 2'b00) m_st = M_IDLE;
      else begin
         case (m_st)
            M_IDLE: begin
               if (ae)      begin m_st = M_ALARM; m_ticks = 0; restart = 1; end
               else if (te) begin m_st = M_CHIME; m_ticks = 0; restart = 1; end
            end
            M_ALARM: begin
               if (s) begin
`ifdef BUZZER_SNOOZE_EN
                  m_st = M_SNOOZE; m_ticks = 0;
`else
                  m_st = M_IDLE;
`endif
               end else if (k) begin
                  m_ticks++;
                  if (m_ticks == AL_S) m_st = M_IDLE;
                  else if (m_ticks % 2 == 0) restart = 1;
               end
            end
            M_CHIME: begin
               if (ae)     begin m_st = M_ALARM; m_ticks = 0; restart = 1; end
               else if (s) m_st = M_IDLE;
               else if (k) begin
                  m_ticks++;
                  if (m_ticks == CH_S) m_st = M_IDLE;
               end
            end
            M_SNOOZE: begin
               if (ae)      begin m_st = M_ALARM; m_ticks = 0; restart = 1; end
               else if (te) begin m_st = M_CHIME; m_ticks = 0; restart = 1; end
               else if (s)  m_st = M_IDLE;
               else if (k) begin
                  m_ticks++;
                  if (m_ticks == SN_S) begin m_st = M_ALARM; m_ticks = 0; restart = 1; end
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
      m_seg = restart ? 0 : m_seg + 1;
   endfunction

   // Expected {buzzer, alarm_active, chime_active}.
   function automatic logic [2:0] model_out();
      logic buz = 1'b0;
      if (m_st == M_CHIME) buz = ((m_seg / CH_HALF) % 2) == 1;
      else if (m_st == M_ALARM && (m_ticks % 2) == 0) buz = ((m_seg / AL_HALF) % 2) == 1;
      return {buz, (m_st == M_ALARM) || (m_st == M_SNOOZE), m_st == M_CHIME};
   endfunction

   function automatic logic [2:0] dut_out();
      return {bus.buzzer, bus.alarm_active, bus.chime_active};
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, return at negedge.
   task automatic step(input bit a, input bit t, input bit s, input bit k, input bit [1:0] md);
      bus.alarm_ring = a; bus.time_ring = t; bus.stop_key = s;
      bus.clk_1hz = k; bus.mode = md;
      @(posedge clk);
      model_step(a, t, s, k, md);
      @(negedge clk);
      bus.stop_key = 1'b0;
      bus.clk_1hz  = 1'b0;
   endtask

   task automatic settle();
      step(0, 0, 0, 0, 2'b01);
      step(0, 0, 0, 0, 2'b01);
      step(0, 0, 0, 0, 2'b00);
   endtask

   task automatic test_reset();
      bus.alarm_ring = 0; bus.time_ring = 0; bus.stop_key = 0;
      bus.clk_1hz = 0; bus.mode = 2'b00;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL reset_outputs got=%b exp=000", dut_out());
      else n_pass++;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL reset_release got=%b exp=000", dut_out());
      else n_pass++;
   endtask

   task automatic test_alarm();
      settle();
      step(1, 0, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b010) $display("FAIL alarm_entry got=%b exp=010", dut_out());
      else n_pass++;
      for (int i = 1; i < 1000; i++) begin
         step(1, 0, 0, 0, 2'b00);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL alarm_hold cyc=%0d got=%b exp=%b", i, dut_out(), model_out());
         else n_pass++;
         if (i == 5) begin
            n_checks++;
            if (bus.buzzer !== 1'b1) $display("FAIL alarm_first_toggle got=%b exp=1", bus.buzzer);
            else n_pass++;
         end
      end
      for (int p = 1; p <= 4; p++) begin
         step(1, 0, 0, 1, 2'b00);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL alarm_tick%0d got=%b exp=%b", p, dut_out(), model_out());
         else n_pass++;
         if (p == 4) begin
            n_checks++;
            if (dut_out() !== 3'b000) $display("FAIL alarm_expire got=%b exp=000", dut_out());
            else n_pass++;
         end
         for (int i = 0; i < 49; i++) begin
            step(1, 0, 0, 0, 2'b00);
            n_checks++;
            if (dut_out() !== model_out()) $display("FAIL alarm_sec%0d cyc=%0d got=%b exp=%b", p, i, dut_out(), model_out());
            else n_pass++;
         end
      end
   endtask

   task automatic test_chime();
      settle();
      step(0, 1, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b001) $display("FAIL chime_entry got=%b exp=001", dut_out());
      else n_pass++;
      for (int p = 0; p <= 2; p++) begin
         if (p > 0) step(0, 1, 0, 1, 2'b00);
         for (int i = 1; i < 40; i++) begin
            step(0, 1, 0, 0, 2'b00);
            n_checks++;
            if (dut_out() !== model_out()) $display("FAIL chime_run sec=%0d cyc=%0d got=%b exp=%b", p, i, dut_out(), model_out());
            else n_pass++;
            if (p == 0 && i == 10) begin
               n_checks++;
               if (bus.buzzer !== 1'b1) $display("FAIL chime_first_toggle got=%b exp=1", bus.buzzer);
               else n_pass++;
            end
         end
      end
      // time_ring still held high: no retrigger.
      for (int i = 0; i < 100; i++) begin
         step(0, 1, 0, 0, 2'b00);
         n_checks++;
         if (dut_out() !== 3'b000) $display("FAIL chime_no_retrigger cyc=%0d got=%b exp=000", i, dut_out());
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      settle();
      step(1, 1, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b010) $display("FAIL both_edges got=%b exp=010", dut_out());
      else n_pass++;
      step(1, 0, 0, 0, 2'b00);
      step(1, 1, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== model_out() || bus.chime_active !== 1'b0)
         $display("FAIL chime_in_alarm got=%b exp=%b", dut_out(), model_out());
      else n_pass++;
      settle();
      step(0, 1, 0, 0, 2'b00);
      repeat (5) step(0, 1, 0, 0, 2'b00);
      step(0, 1, 0, 1, 2'b00);
      step(1, 1, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b010) $display("FAIL preempt got=%b exp=010", dut_out());
      else n_pass++;
      // Full reload: alarm lasts another four seconds.
      for (int p = 1; p <= 4; p++) begin
         for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, 2'b00);
            n_checks++;
            if (dut_out() !== model_out()) $display("FAIL preempt_run sec=%0d got=%b exp=%b", p, dut_out(), model_out());
            else n_pass++;
         end
         step(1, 1, 0, 1, 2'b00);
         n_checks++;
         if (bus.alarm_active !== (p < 4)) $display("FAIL preempt_reload tick=%0d got=%b exp=%b", p, bus.alarm_active, p < 4);
         else n_pass++;
      end
   endtask

   task automatic test_stop_mode();
      settle();
      step(1, 0, 1, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b010) $display("FAIL entry_beats_stop got=%b exp=010", dut_out());
      else n_pass++;
      repeat (7) step(1, 0, 0, 0, 2'b00);
      step(1, 0, 1, 0, 2'b00);
      n_checks++;
`ifdef BUZZER_SNOOZE_EN
      if (dut_out() !== 3'b010) $display("FAIL stop_alarm got=%b exp=010", dut_out());
`else
      if (dut_out() !== 3'b000) $display("FAIL stop_alarm got=%b exp=000", dut_out());
`endif
      else n_pass++;
      settle();
      step(0, 1, 0, 0, 2'b00);
      repeat (7) step(0, 1, 0, 0, 2'b00);
      step(0, 1, 0, 0, 2'b10);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL mode_exit got=%b exp=000", dut_out());
      else n_pass++;
      step(0, 0, 0, 0, 2'b10);
      step(1, 1, 0, 0, 2'b10);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL mode_blocks got=%b exp=000", dut_out());
      else n_pass++;
      step(1, 1, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL mode_held_level got=%b exp=000", dut_out());
      else n_pass++;
   endtask

`ifdef BUZZER_SNOOZE_EN
   task automatic test_snooze();
      settle();
      step(1, 0, 0, 0, 2'b00);
      repeat (6) step(1, 0, 0, 0, 2'b00);
      step(1, 0, 1, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b010) $display("FAIL snooze_enter got=%b exp=010", dut_out());
      else n_pass++;
      for (int p = 1; p <= 3; p++) begin
         for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 2'b00);
            n_checks++;
            if (dut_out() !== 3'b010) $display("FAIL snooze_quiet got=%b exp=010", dut_out());
            else n_pass++;
         end
         step(1, 0, 0, 1, 2'b00);
      end
      for (int i = 0; i < 30; i++) begin
         step(1, 0, 0, 0, 2'b00);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL snooze_rering got=%b exp=%b", dut_out(), model_out());
         else n_pass++;
      end
      step(1, 0, 1, 0, 2'b00);
      step(1, 0, 1, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL snooze_stop got=%b exp=000", dut_out());
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      bit a = 0, t = 0;
      settle();
      for (int i = 0; i < 4000; i++) begin
         bit s, k;
         bit [1:0] md;
         if ($urandom_range(0, 99) < 3) a = ~a;
         if ($urandom_range(0, 99) < 3) t = ~t;
         s  = $urandom_range(0, 99) < 2;
         k  = $urandom_range(0, 99) < 6;
         md = ($urandom_range(0, 99) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
         step(a, t, s, k, md);
         n_checks++;
         if (dut_out() !== model_out()) $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_out(), model_out());
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      bit seen = 0;
      settle();
      step(1, 0, 0, 0, 2'b00);
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1, 0, 0, 0, 2'b00);
         seen = (bus.buzzer === 1'b1);
      end
      n_checks++;
      if (!seen) $display("FAIL async_wait_buzzer got=0 exp=1");
      else n_pass++;
      #2;
      rst_n = 1'b0;
      bus.alarm_ring = 1'b0;
      #1;
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL async_reset got=%b exp=000", dut_out());
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(0, 0, 0, 0, 2'b00);
      n_checks++;
      if (dut_out() !== 3'b000) $display("FAIL async_release got=%b exp=000", dut_out());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_alarm();
      test_chime();
      test_priority();
      test_stop_mode();
`ifdef BUZZER_SNOOZE_EN
      test_snooze();
`endif
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
